// File: rtl/fetch_queue.sv
// fetch_queue: multi-wide fetch stage feeding decode through a DEPTH-entry circular instruction queue.
// Define FETCH_QUEUE_PERF_EN to add the perf_blocks/perf_drops/perf_full_stalls counters.
module fetch_queue #(
  parameter int          FETCH_W  = 2,
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     ic_req_valid,
  output logic [31:0]              ic_req_addr,
  input  logic                     ic_resp_valid,
  input  logic [32*FETCH_W-1:0]    ic_resp_data,
  input  logic                     ready_out,
  output logic                     valid_out,
  output logic [31:0]              instr_out,
  output logic [31:0]              pc_out,
  output logic [31:0]              pc_4,
  output logic [$clog2(DEPTH):0]   occupancy
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]              perf_blocks,
  output logic [31:0]              perf_drops,
  output logic [31:0]              perf_full_stalls
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] BMASK = 32'(FETCH_W * 4 - 1);
  typedef enum logic [1:0] {RUN, WAIT, DROP} state_t;
  state_t state_q, state_d;
  logic [31:0] fpc_q, fpc_d, blk, off;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, nenq;
  logic [31:0] pc_mem [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic fits, req, resp_enq, resp_drop, deq;
  assign valid_out    = count_q != '0;
  assign pc_out       = pc_mem[head_q];
  assign instr_out    = instr_mem[head_q];
  assign pc_4         = pc_out + 32'd4;
  assign occupancy    = count_q;
  assign ic_req_valid = req;
  assign ic_req_addr  = blk;
  always_comb begin
    blk       = fpc_q & ~BMASK;
    off       = (fpc_q >> 2) & 32'(FETCH_W - 1);
    fits      = (CW'(DEPTH) - count_q) >= CW'(FETCH_W);
    req       = state_q == RUN && !redirect_valid && fits && !reset;
    resp_enq  = state_q == WAIT && ic_resp_valid && !redirect_valid;
    resp_drop = ic_resp_valid && (state_q == DROP || (state_q == WAIT && redirect_valid));
    deq       = valid_out && ready_out && !redirect_valid;
    nenq      = resp_enq ? CW'(FETCH_W) - CW'(off) : '0;
    // A response always ends WAIT; a redirect without one leaves a stale request to drop.
    state_d   = state_q == RUN  ? (req ? WAIT : RUN)
              : state_q == WAIT ? (ic_resp_valid ? RUN : redirect_valid ? DROP : WAIT)
              : (ic_resp_valid && !redirect_valid ? RUN : DROP);
    count_d   = redirect_valid ? '0 : count_q + nenq - CW'(deq);
    head_d    = redirect_valid ? tail_q : head_q + PW'(deq);
    tail_d    = tail_q + PW'(nenq);
    fpc_d     = redirect_valid ? redirect_pc & ~32'h3
              : resp_enq ? blk + 32'(FETCH_W * 4) : fpc_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      fpc_q   <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  // Lanes below the fetch offset are skipped; the rest pack contiguously from tail.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_W; i++) begin
      if (resp_enq && 32'(i) >= off) begin
        pc_mem[tail_q + PW'(32'(i) - off)]    <= blk + 32'(4 * i);
        instr_mem[tail_q + PW'(32'(i) - off)] <= ic_resp_data[32*i +: 32];
      end
    end
  end
`ifdef FETCH_QUEUE_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_blocks      <= '0;
      perf_drops       <= '0;
      perf_full_stalls <= '0;
    end else begin
      perf_blocks      <= perf_blocks + 32'(resp_enq);
      perf_drops       <= perf_drops + 32'(resp_drop);
      perf_full_stalls <= perf_full_stalls + 32'(state_q == RUN && !redirect_valid && !fits);
    end
  end
`endif
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised multi-wide fetch stage with an internal instruction queue, between the PC/redirect logic and decode. Owns the fetch PC and issues aligned block requests of FETCH_W instructions to the instruction cache. It buffers the returned instructions in a DEPTH-entry circular queue and delivers one {pc, instr} per valid/ready handshake to decode. A redirect flushes the queue and discards any in-flight cache response.

## Interface
- FETCH_W, 2: instructions per cache block; power of two, 1..8
- DEPTH, 8: queue entries; power of two, ≥ 2·FETCH_W
- RESET_PC, 32'h0: fetch PC after reset
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- redirect_valid  in  1  mispredict/redirect strobe
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored and treated as 0
- ic_req_valid  out  1  cache request this cycle
- ic_req_addr  out  32  block-aligned address: fpc with low log2(FETCH_W)+2 bits cleared
- ic_resp_valid  in  1  response strobe; any cycle after the request
- ic_resp_data  in  32·FETCH_W  lane i = instruction at block+4i
- ready_out  in  1  decode accepts
- valid_out  out  1  head entry valid
- instr_out  out  32  head instruction
- pc_out  out  32  head PC
- pc_4  out  32  pc_out+4, mod 2^32
- occupancy  out  $clog2(DEPTH)+1  entries held

## Operation
- State: fpc (32b), head/tail pointers (log2 DEPTH, natural wrap), count, FSM {RUN, WAIT, DROP}.
- RUN: ic_req_valid=1 when DEPTH−count ≥ FETCH_W and no redirect. Then → WAIT. Otherwise stay.
- WAIT: on ic_resp_valid, offset = fpc[log2(FETCH_W)+1:2]. Enqueue lanes offset..FETCH_W−1 in order; lane i gets pc=block+4i. Then fpc ← block+4·FETCH_W with 32-bit wrap, → RUN.
- DROP: the next ic_resp_valid is discarded, then → RUN. Only one request is ever outstanding.
- Redirect has priority over everything. Next cycle count=0 and head=tail. fpc ← redirect_pc&~3.
- Redirect in WAIT without a same-cycle response → DROP.
- Redirect in WAIT with a same-cycle response: response discarded, → RUN.
- Redirect in DROP: stay DROP. Redirect in RUN: stay RUN, no request that cycle.
- Dequeue when valid_out&&ready_out: head++, count−−. Ignored in a redirect cycle.
- Enqueue and dequeue in the same cycle are both performed.
- The request free-space check uses the current count, before dequeue.
- The free-space check guarantees no overflow. Underflow is impossible because valid_out=(count≠0).
- Outputs valid_out, instr_out, pc_out, pc_4 are combinational from head-entry registers. Data is don't-care when valid_out=0.

## Timing
- Reset values: count=0, valid_out=0, occupancy=0, FSM=RUN, fpc=RESET_PC. ic_req_valid is forced 0 while reset is high.
- First request is in the first cycle after reset deasserts.
- Latency: an instruction enqueued at edge N shows on valid_out after edge N, i.e. in cycle N+1.
- Peak throughput: FETCH_W instructions per 2 cycles (request cycle + response cycle), with a 1-cycle cache.
- Redirect at edge N: all entries lost, and valid_out=0 in cycle N+1. The new request is issued in cycle N+1 if state is RUN, or after the dropped response if state is DROP.
- Reset mid-operation clears the FSM. A cache response arriving after reset is ignored, because the FSM is in RUN, not WAIT.

## Configuration
- FETCH_QUEUE_PERF_EN defined: adds outputs perf_blocks (32b, responses enqueued), perf_drops (32b, responses discarded), perf_full_stalls (32b, RUN cycles blocked by free space). All reset to 0, wrap at 2^32, and are not cleared by redirect.
- Undefined: the ports and counters are absent, and functional behaviour is identical.

## Test plan
- FETCH_W=2, RESET_PC=0, ready_out=1, 1-cycle cache: pc_out sequence 0,4,8,12…, with no gaps in instr values beyond the 2-per-2-cycle rate.
- Redirect to 0x106 in WAIT: ic_req_addr=0x100 (low bits cleared). Only the lane at pc 0x104 is enqueued. Next block 0x108.
- Redirect during WAIT, response 3 cycles later: that response is not enqueued. perf_drops=1. Next request addr = the redirect block.
- ready_out=0 with DEPTH=8, FETCH_W=2: occupancy stops at 8 and ic_req_valid stays 0. One dequeue (occupancy 7) → still no request; two dequeues (occupancy 6) → request.
- Redirect in the same cycle as ready_out=1 at occupancy 5: next cycle occupancy=0 and valid_out=0, and the head was not counted as dequeued.
- fpc=0xFFFFFFF8, FETCH_W=2: PCs 0xFFFFFFF8 and 0xFFFFFFFC are enqueued, and the next request addr is 0x0. Reset asserted in WAIT → occupancy=0 and the late response is ignored.
